// File: rtl/data_mmio_responder_if.sv
// data_mmio_responder_if
//   CPU data-memory request/response bundle.
//   Signals:
//     data_sram_we     write strobe for this cycle
//     data_sram_addr   byte address (bits [1:0] ignored by the responder)
//     data_sram_wdata  write data
//     data_sram_rdata  combinational read data from the responder
//   Modports: master (CPU side) drives the request, slave (responder) returns rdata.
interface data_mmio_responder_if;
   logic        data_sram_we;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;

   modport master (
      output data_sram_we,
      output data_sram_addr,
      output data_sram_wdata,
      input  data_sram_rdata
   );

   modport slave (
      input  data_sram_we,
      input  data_sram_addr,
      input  data_sram_wdata,
      output data_sram_rdata
   );
endinterface

// File: rtl/data_mmio_responder.sv
// data_mmio_responder
//   Answers CPU data-memory requests: a word RAM for ordinary addresses and
//   a small MMIO window (0xbfafxxxx) holding a free-running timer, a 16-bit
//   LED register and a byte console TX FIFO. Reads are combinational, writes
//   commit on the rising edge of clk.
//   Ports:
//     clk, reset      single clock, synchronous active-high reset
//     bus             data_sram_* request bundle (slave side)
//     led             LED register contents
//     tx_valid        FIFO head byte available
//     tx_data         FIFO head byte (0 when empty)
//     tx_ready        consumer accepts the head byte this cycle
module data_mmio_responder #(
   parameter int RAM_AW  = 10,
   parameter int FIFO_AW = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   data_mmio_responder_if.slave  bus,
   output logic [15:0]           led,
   output logic                  tx_valid,
   output logic [7:0]            tx_data,
   input  logic                  tx_ready
);

   localparam int          DEPTH      = 1 << FIFO_AW;
   localparam logic [15:0] MMIO_BASE  = 16'hbfaf;
   localparam logic [15:0] OFF_TIMER  = 16'hf000;
   localparam logic [15:0] OFF_TXDATA = 16'hf010;
   localparam logic [15:0] OFF_STATUS = 16'hf014;
   localparam logic [15:0] OFF_LED    = 16'hf020;

   // ---------------- address decode ----------------
   logic              is_mmio;
   logic [13:0]       word_off;
   logic [RAM_AW-1:0] ram_idx;
   logic              wr_timer, wr_txdata, wr_status, wr_led, wr_ram;

   assign is_mmio   = (bus.data_sram_addr[31:16] == MMIO_BASE);
   assign word_off  = bus.data_sram_addr[15:2];
   assign ram_idx   = bus.data_sram_addr[RAM_AW+1:2];

   assign wr_ram    = bus.data_sram_we & ~is_mmio;
   assign wr_timer  = bus.data_sram_we & is_mmio & (word_off == OFF_TIMER[15:2]);
   assign wr_txdata = bus.data_sram_we & is_mmio & (word_off == OFF_TXDATA[15:2]);
   assign wr_status = bus.data_sram_we & is_mmio & (word_off == OFF_STATUS[15:2]);
   assign wr_led    = bus.data_sram_we & is_mmio & (word_off == OFF_LED[15:2]);

   // Byte-lane bits never take part in decode.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^bus.data_sram_addr[1:0];

   // ---------------- storage (no reset) ----------------
   logic [31:0] ram_mem  [2**RAM_AW];
   logic [7:0]  fifo_mem [DEPTH];

   // ---------------- state ----------------
   logic [31:0]        timer_reg,  timer_next;
   logic [15:0]        led_reg,    led_next;
   logic [FIFO_AW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [FIFO_AW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [FIFO_AW:0]   count_reg,  count_next;
   logic               ovf_reg,    ovf_next;

   logic fifo_full, fifo_empty, pop, push, overflow;
   logic [3:0] count4;

   assign fifo_empty = (count_reg == '0);
   assign fifo_full  = (count_reg == (FIFO_AW+1)'(DEPTH));
   assign count4     = 4'(count_reg);

   assign tx_valid = ~fifo_empty;
   assign tx_data  = tx_valid ? fifo_mem[rd_ptr_reg] : 8'h00;
   assign led      = led_reg;

   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign pop      = tx_valid & tx_ready;
   assign push     = wr_txdata & (~fifo_full | pop);
   assign overflow = wr_txdata & fifo_full & ~pop;

   always_comb begin
      timer_next  = wr_timer ? bus.data_sram_wdata : timer_reg + 32'd1;
      led_next    = wr_led ? bus.data_sram_wdata[15:0] : led_reg;
      rd_ptr_next = pop  ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
      wr_ptr_next = push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
      count_next  = count_reg;
      if (push && !pop)
         count_next = count_reg + 1'b1;
      else if (pop && !push)
         count_next = count_reg - 1'b1;
      // Overflow has priority over a same-cycle clear.
      ovf_next = ovf_reg;
      if (overflow)
         ovf_next = 1'b1;
      else if (wr_status && bus.data_sram_wdata[2])
         ovf_next = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         timer_reg  <= '0;
         led_reg    <= '0;
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
         ovf_reg    <= 1'b0;
      end else begin
         timer_reg  <= timer_next;
         led_reg    <= led_next;
         rd_ptr_reg <= rd_ptr_next;
         wr_ptr_reg <= wr_ptr_next;
         count_reg  <= count_next;
         ovf_reg    <= ovf_next;
      end
   end

   // RAM and FIFO payload survive reset; only the FIFO pointers are cleared.
   always_ff @(posedge clk) begin
      if (wr_ram)
         ram_mem[ram_idx] <= bus.data_sram_wdata;
   end

   always_ff @(posedge clk) begin
      if (push && !reset)
         fifo_mem[wr_ptr_reg] <= bus.data_sram_wdata[7:0];
   end

   // ---------------- read mux ----------------
   always_comb begin
      bus.data_sram_rdata = 32'h0;
      if (!is_mmio) begin
         bus.data_sram_rdata = ram_mem[ram_idx];
      end else begin
         case (word_off)
            OFF_TIMER[15:2]:  bus.data_sram_rdata = timer_reg;
            OFF_STATUS[15:2]: bus.data_sram_rdata = {24'h0, count4, 1'b0,
                                                     ovf_reg, fifo_full, fifo_empty};
            OFF_LED[15:2]:    bus.data_sram_rdata = {16'h0, led_reg};
            default:          bus.data_sram_rdata = 32'h0;
         endcase
      end
   end

endmodule
